multibank_pingpong_ctrl: RTL
============================

# multibank_pingpong_ctrl

Parametrised N-bank successor of the two-bank west/north ping-pong controller in the Multi-Head Attention datapath. It accepts input beats with a valid/ready handshake and slices each beat into TOTAL_MODULES bank writes. It fills banks in round-robin order and drains full banks through the systolic array tile by tile, over ROW_Y × COL_Y output tiles. Unlike the two-bank version it has backpressure, more than one output row, a frame-end `done`, and per-tile row/column tags.

## Interface
- NUM_BANKS, 2: bank count, ≥2. Read and write pointers wrap modulo NUM_BANKS.
- TOTAL_MODULES, 4: slices per accepted beat.
- ADDR_WIDTH_W, 4 / ADDR_WIDTH_N, 4: west / north address widths.
- W_DEPTH, 4: west words per port per bank. Port B is offset by W_DEPTH.
- N_DEPTH, 4: north words per bank.
- INNER_BLOCKS, 2: inner dimension / BLOCK_SIZE (k steps per tile).
- ROW_Y, 1 / COL_Y, 2: output tile rows / columns per bank.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid / in_ready  in / out  1  input beat handshake.
- in_last  in  1  beat belongs to the final frame. Sampled on accept.
- w_en, w_we  out  NUM_BANKS  west bank enable / write (both ports).
- w_addra, w_addrb  out  NUM_BANKS*ADDR_WIDTH_W  west addresses, bank b at [b*AW +: AW].
- n_en, n_we  out  NUM_BANKS  north enable / write.
- n_addr  out  NUM_BANKS*ADDR_WIDTH_N  north address.
- slicing_idx  out  $clog2(TOTAL_MODULES)  slice being written.
- rd_bank  out  $clog2(NUM_BANKS)  bank selected for reading.
- systolic_finish, acc_done  in  1  systolic step complete / accumulation complete (level).
- enable_matmul  out  1  reader active.
- acc_clear  out  1  one-cycle pulse at each tile start.
- out_valid  out  1  one-cycle pulse per finished tile.
- out_row, out_col  out  8  tile indices, valid with out_valid.
- done  out  1  sticky, set after the last-frame bank drains.

## Operation
**Write side**
- State: `wr_ptr`, `slicing` flag, `slicing_idx`, west counter `wa` (0..W_DEPTH-1), north counter `na` (0..N_DEPTH-1), per-side done bits, `bank_full[NUM_BANKS]`, `bank_last[NUM_BANKS]`.
- `in_ready = !slicing && !bank_full[wr_ptr] && !done`.
- On accept, `slicing` is set and `bank_last[wr_ptr] |= in_last`.
- Each slicing cycle:
  - West side, unless its done bit is set: `w_we[wr_ptr]` high, addra = `wa`, addrb = `wa` + W_DEPTH.
  - North side, unless its done bit is set: `n_we[wr_ptr]` high, addr = `na`.
  - Each counter wraps to 0 at depth-1 and sets its side done bit.
  - `slicing_idx` increments. `slicing` clears after index TOTAL_MODULES-1.
- When both side done bits are set: `bank_full[wr_ptr]` is set, `wr_ptr` advances, counters and done bits clear.

**Read side** (FSM: R_IDLE, R_START, R_RUN, R_WAIT_ACC, R_RELEASE)
- R_IDLE: go to R_START when `bank_full[rd_ptr]`. Clear `r`, `c`, `k`.
- R_START: pulse `acc_clear`, then go to R_RUN.
- R_RUN: drive read addresses on bank `rd_ptr`:
  - addra = `k` + INNER_BLOCKS*2r
  - addrb = `k` + INNER_BLOCKS*(2r+1)
  - north = `k` + INNER_BLOCKS*c
  - Arithmetic is unsigned and truncated to the address width.
  - On `systolic_finish`: `k`++. At INNER_BLOCKS-1, `k` wraps and the FSM goes to R_WAIT_ACC.
- R_WAIT_ACC: on the rising edge of `acc_done`, pulse `out_valid` with `out_row` = `r`, `out_col` = `c`. Then advance `c`, then `r`.
  - If this was the last tile: go to R_RELEASE.
  - Otherwise: go to R_START.
- R_RELEASE: clear `bank_full[rd_ptr]` and `bank_last[rd_ptr]`. If the bank was tagged last, set `done`. Advance `rd_ptr`, return to R_IDLE.

**Enables and priority**
- `enable_matmul` = FSM in R_START, R_RUN or R_WAIT_ACC.
- `w_en`/`n_en` are high for the write bank while slicing and for `rd_bank` while the reader is active. Otherwise they are low.
- Idle addresses are 0.
- Write takes priority; `wr_ptr` == `rd_ptr` with both active cannot occur, because a full bank is never written.

## Timing
- Reset: every output is 0, except `in_ready`, which is 1 one cycle after reset release. `done` clears only on reset.
- Write side: the first `we` occurs in the cycle after accept. A beat occupies TOTAL_MODULES cycles. `in_ready` returns the cycle after the last slice.
- Read side:
  - `bank_full` rising → R_START on the next cycle.
  - Addresses update the cycle after `systolic_finish`.
  - `out_valid` occurs 1 cycle after the `acc_done` rising edge.
- `acc_done` is edge-detected with a register; a held level counts once.
- If a bank fills and another bank is released in the same cycle, both updates apply.
- `rst_n` low mid-slice or mid-read aborts immediately. There is no partial-bank state carry-over.

## Test plan
- NUM_BANKS=2, W_DEPTH=N_DEPTH=TOTAL_MODULES=4: one beat → `w_we[0]` for 4 cycles, addra 0..3, addrb 4..7, `bank_full[0]`, `rd_bank`=0, `acc_clear` pulse.
- Reader with INNER_BLOCKS=2, ROW_Y=2, COL_Y=2 → north addrs 0,1 then 2,3. At r=1, west addra 4,5 and addrb 6,7. `out_valid` ×4 with (r,c) = (0,0), (0,1), (1,0), (1,1).
- NUM_BANKS=3 with a stalled reader (`systolic_finish` held low) → three beats accepted, fourth sees `in_ready`=0 until R_RELEASE. Writes land on banks 0, 1, 2, then 0.
- `in_last` on the second beat → `done` rises exactly after bank 1 releases. `in_ready` stays 0 afterwards.
- `acc_done` held high for 5 cycles → exactly one `out_valid`.
- `rst_n` low during slice 2 → all outputs 0 next cycle. A new beat restarts at bank 0, address 0.

Source files
------------

// File: rtl/multibank_pingpong_ctrl.sv
// N-bank ping-pong controller: slices accepted input beats into round-robin bank writes
// and drains each full bank through the systolic array one output tile at a time.
module multibank_pingpong_ctrl #(
   parameter int NUM_BANKS     = 2,
   parameter int TOTAL_MODULES = 4,
   parameter int ADDR_WIDTH_W  = 4,
   parameter int ADDR_WIDTH_N  = 4,
   parameter int W_DEPTH       = 4,
   parameter int N_DEPTH       = 4,
   parameter int INNER_BLOCKS  = 2,
   parameter int ROW_Y         = 1,
   parameter int COL_Y         = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_last,
   output logic [NUM_BANKS-1:0]                 w_en,
   output logic [NUM_BANKS-1:0]                 w_we,
   output logic [NUM_BANKS*ADDR_WIDTH_W-1:0]    w_addra,
   output logic [NUM_BANKS*ADDR_WIDTH_W-1:0]    w_addrb,
   output logic [NUM_BANKS-1:0]                 n_en,
   output logic [NUM_BANKS-1:0]                 n_we,
   output logic [NUM_BANKS*ADDR_WIDTH_N-1:0]    n_addr,
   output logic [$clog2(TOTAL_MODULES)-1:0]     slicing_idx,
   output logic [$clog2(NUM_BANKS)-1:0]         rd_bank,
   input  logic                                 systolic_finish,
   input  logic                                 acc_done,
   output logic                                 enable_matmul,
   output logic                                 acc_clear,
   output logic                                 out_valid,
   output logic [7:0]                           out_row,
   output logic [7:0]                           out_col,
   output logic                                 done
);

   localparam int PW = $clog2(NUM_BANKS);
   localparam int SW = $clog2(TOTAL_MODULES);

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_RUN,
      R_WAIT_ACC,
      R_RELEASE
   } rd_state_e;

   rd_state_e state_q, state_d;

   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                    slicing_q, slicing_d;
   logic [SW-1:0]           slicing_idx_q, slicing_idx_d;
   logic [ADDR_WIDTH_W-1:0] wa_q, wa_d;
   logic [ADDR_WIDTH_N-1:0] na_q, na_d;
   logic                    w_done_q, w_done_d, n_done_q, n_done_d;
   logic [NUM_BANKS-1:0]    bank_full_q, bank_full_d, bank_last_q, bank_last_d;
   logic [NUM_BANKS-1:0]    bank_full_set, bank_last_set, bank_full_clr, bank_last_clr;
   logic                    done_q, done_d;
   logic                    ready_en_q;
   logic [7:0]              r_q, r_d, c_q, c_d, k_q, k_d;
   logic                    acc_done_q;
   logic                    out_valid_q, out_valid_d;
   logic [7:0]              out_row_q, out_row_d, out_col_q, out_col_d;
   logic                    w_wr, n_wr, acc_rise;

   assign w_wr     = slicing_q && !w_done_q;
   assign n_wr     = slicing_q && !n_done_q;
   assign acc_rise = acc_done && !acc_done_q;

   // Write side: a bank is committed only once both sides have wrapped and the beat has ended.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      slicing_d     = slicing_q;
      slicing_idx_d = slicing_idx_q;
      wa_d          = wa_q;
      na_d          = na_q;
      w_done_d      = w_done_q;
      n_done_d      = n_done_q;
      bank_full_set = '0;
      bank_last_set = '0;
      in_ready      = ready_en_q && !slicing_q && !bank_full_q[wr_ptr_q] && !done_q;

      if (in_valid && in_ready) begin
         slicing_d     = 1'b1;
         slicing_idx_d = '0;
         if (in_last) bank_last_set[wr_ptr_q] = 1'b1;
      end

      if (slicing_q) begin
         if (w_wr) begin
            if (wa_q == ADDR_WIDTH_W'(W_DEPTH - 1)) begin
               wa_d     = '0;
               w_done_d = 1'b1;
            end else begin
               wa_d = wa_q + 1'b1;
            end
         end
         if (n_wr) begin
            if (na_q == ADDR_WIDTH_N'(N_DEPTH - 1)) begin
               na_d     = '0;
               n_done_d = 1'b1;
            end else begin
               na_d = na_q + 1'b1;
            end
         end
         if (slicing_idx_q == SW'(TOTAL_MODULES - 1)) begin
            slicing_d     = 1'b0;
            slicing_idx_d = '0;
         end else begin
            slicing_idx_d = slicing_idx_q + 1'b1;
         end
         if (!slicing_d && w_done_d && n_done_d) begin
            bank_full_set[wr_ptr_q] = 1'b1;
            wr_ptr_d = (wr_ptr_q == PW'(NUM_BANKS - 1)) ? '0 : wr_ptr_q + 1'b1;
            wa_d     = '0;
            na_d     = '0;
            w_done_d = 1'b0;
            n_done_d = 1'b0;
         end
      end
   end

   // Read side FSM walks tiles column-first within each row.
   always_comb begin
      state_d       = state_q;
      rd_ptr_d      = rd_ptr_q;
      r_d           = r_q;
      c_d           = c_q;
      k_d           = k_q;
      done_d        = done_q;
      bank_full_clr = '0;
      bank_last_clr = '0;
      out_valid_d   = 1'b0;
      out_row_d     = out_row_q;
      out_col_d     = out_col_q;
      acc_clear     = 1'b0;

      case (state_q)
         R_IDLE: begin
            r_d = '0;
            c_d = '0;
            k_d = '0;
            if (bank_full_q[rd_ptr_q]) state_d = R_START;
         end
         R_START: begin
            acc_clear = 1'b1;
            state_d   = R_RUN;
         end
         R_RUN: begin
            if (systolic_finish) begin
               if (k_q == 8'(INNER_BLOCKS - 1)) begin
                  k_d     = '0;
                  state_d = R_WAIT_ACC;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         R_WAIT_ACC: begin
            if (acc_rise) begin
               out_valid_d = 1'b1;
               out_row_d   = r_q;
               out_col_d   = c_q;
               state_d     = R_START;
               if (c_q == 8'(COL_Y - 1)) begin
                  c_d = '0;
                  if (r_q == 8'(ROW_Y - 1)) begin
                     r_d     = '0;
                     state_d = R_RELEASE;
                  end else begin
                     r_d = r_q + 1'b1;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         R_RELEASE: begin
            bank_full_clr[rd_ptr_q] = 1'b1;
            bank_last_clr[rd_ptr_q] = 1'b1;
            if (bank_last_q[rd_ptr_q]) done_d = 1'b1;
            rd_ptr_d = (rd_ptr_q == PW'(NUM_BANKS - 1)) ? '0 : rd_ptr_q + 1'b1;
            state_d  = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign bank_full_d = (bank_full_q | bank_full_set) & ~bank_full_clr;
   assign bank_last_d = (bank_last_q | bank_last_set) & ~bank_last_clr;

   // Bank strobes and addresses; the write bank is applied last so it wins any overlap.
   always_comb begin
      enable_matmul = (state_q == R_START) || (state_q == R_RUN) || (state_q == R_WAIT_ACC);
      w_en    = '0;
      w_we    = '0;
      n_en    = '0;
      n_we    = '0;
      w_addra = '0;
      w_addrb = '0;
      n_addr  = '0;

      if (enable_matmul) begin
         w_en[rd_ptr_q] = 1'b1;
         n_en[rd_ptr_q] = 1'b1;
      end
      if (state_q == R_RUN) begin
         w_addra[rd_ptr_q*ADDR_WIDTH_W +: ADDR_WIDTH_W] =
            ADDR_WIDTH_W'(32'(k_q) + 32'(INNER_BLOCKS) * (32'(r_q) * 32'd2));
         w_addrb[rd_ptr_q*ADDR_WIDTH_W +: ADDR_WIDTH_W] =
            ADDR_WIDTH_W'(32'(k_q) + 32'(INNER_BLOCKS) * (32'(r_q) * 32'd2 + 32'd1));
         n_addr[rd_ptr_q*ADDR_WIDTH_N +: ADDR_WIDTH_N] =
            ADDR_WIDTH_N'(32'(k_q) + 32'(INNER_BLOCKS) * 32'(c_q));
      end
      if (slicing_q) begin
         w_en[wr_ptr_q] = 1'b1;
         n_en[wr_ptr_q] = 1'b1;
         if (w_wr) begin
            w_we[wr_ptr_q] = 1'b1;
            w_addra[wr_ptr_q*ADDR_WIDTH_W +: ADDR_WIDTH_W] = wa_q;
            w_addrb[wr_ptr_q*ADDR_WIDTH_W +: ADDR_WIDTH_W] = wa_q + ADDR_WIDTH_W'(W_DEPTH);
         end
         if (n_wr) begin
            n_we[wr_ptr_q] = 1'b1;
            n_addr[wr_ptr_q*ADDR_WIDTH_N +: ADDR_WIDTH_N] = na_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= R_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         slicing_q     <= 1'b0;
         slicing_idx_q <= '0;
         wa_q          <= '0;
         na_q          <= '0;
         w_done_q      <= 1'b0;
         n_done_q      <= 1'b0;
         bank_full_q   <= '0;
         bank_last_q   <= '0;
         done_q        <= 1'b0;
         ready_en_q    <= 1'b0;
         r_q           <= '0;
         c_q           <= '0;
         k_q           <= '0;
         acc_done_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_row_q     <= '0;
         out_col_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         slicing_q     <= slicing_d;
         slicing_idx_q <= slicing_idx_d;
         wa_q          <= wa_d;
         na_q          <= na_d;
         w_done_q      <= w_done_d;
         n_done_q      <= n_done_d;
         bank_full_q   <= bank_full_d;
         bank_last_q   <= bank_last_d;
         done_q        <= done_d;
         ready_en_q    <= 1'b1;
         r_q           <= r_d;
         c_q           <= c_d;
         k_q           <= k_d;
         acc_done_q    <= acc_done;
         out_valid_q   <= out_valid_d;
         out_row_q     <= out_row_d;
         out_col_q     <= out_col_d;
      end
   end

   assign slicing_idx = slicing_idx_q;
   assign rd_bank     = rd_ptr_q;
   assign out_valid   = out_valid_q;
   assign out_row     = out_row_q;
   assign out_col     = out_col_q;
   assign done        = done_q;

endmodule
